obj_nav_ctrl: RTL and testbench



---
 rtl/obj_pkg.sv | 30 +++
 rtl/obj_nav_timer.sv | 28 ++
 rtl/obj_nav_ctrl.sv | 138 +++++++++++++
 tb/tb_obj_nav_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/obj_pkg.sv
// Shared encodings for the obstacle-avoidance navigation controller.
// Motor command values and controller state encoding.
package obj_pkg;

    localparam logic [2:0] CMD_STOP    = 3'd0;
    localparam logic [2:0] CMD_FWD     = 3'd1;
    localparam logic [2:0] CMD_PIVOT_L = 3'd2;
    localparam logic [2:0] CMD_PIVOT_R = 3'd3;
    localparam logic [2:0] CMD_REV     = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FWD,
        ST_PIVOT_L,
        ST_PIVOT_R,
        ST_REVERSE,
        ST_HALT
    } nav_state_t;

    function automatic logic [2:0] cmd_of(input nav_state_t s);
        case (s)
            ST_FWD:     return CMD_FWD;
            ST_PIVOT_L: return CMD_PIVOT_L;
            ST_PIVOT_R: return CMD_PIVOT_R;
            ST_REVERSE: return CMD_REV;
            default:    return CMD_STOP;
        endcase
    endfunction

endpackage

// File: rtl/obj_nav_timer.sv
// Loadable down-counter shared by manoeuvre and clear-run timing.
// Holds at zero; done flags the terminal count.
module obj_nav_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/obj_nav_ctrl.sv
// Turns obstacle flags into timed motor manoeuvres with a retry limiter.
// Moore machine: every output is registered from the next-state decode.
module obj_nav_ctrl
    import obj_pkg::*;
#(
    parameter int TURN_CYCLES  = 16,
    parameter int REV_CYCLES   = 8,
    parameter int CLEAR_CYCLES = 32,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           left_object_detected,
    input  logic                           right_object_detected,
    input  logic                           front_object_detected,
    output logic [2:0]                     motor_cmd,
    output logic                           busy,
    output logic                           stuck,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] REV_LD  = CNT_W'(REV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLR_LD  = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [RW-1:0]    MAX_R   = RW'(MAX_RETRY);

    if (TURN_CYCLES < 1 || TURN_CYCLES > 2**CNT_W ||
        REV_CYCLES < 1 || REV_CYCLES > 2**CNT_W ||
        CLEAR_CYCLES < 1 || CLEAR_CYCLES > 2**CNT_W ||
        MAX_RETRY < 1) begin : g_bad_param
        $error("obj_nav_ctrl: cycle parameter out of range");
    end

    nav_state_t       state, state_d;
    logic [RW-1:0]    retry_d;
    logic             t_load, t_dec, t_done;
    logic [CNT_W-1:0] t_val;

    obj_nav_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .dec      (t_dec),
        .done     (t_done)
    );

    always_comb begin
        state_d = state;
        retry_d = retry_cnt;
        t_load  = 1'b0;
        t_val   = '0;
        t_dec   = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            retry_d = '0;
            t_load  = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_d = ST_FWD;
                    t_load  = 1'b1;
                    t_val   = CLR_LD;
                end
                ST_FWD: begin
                    // left pivot preferred; both sides blocked means reverse
                    priority case (1'b1)
                        !front_object_detected: begin
                            t_dec = 1'b1;
                            if (t_done) retry_d = '0;
                        end
                        !left_object_detected: begin
                            state_d = ST_PIVOT_L;
                            t_load  = 1'b1;
                            t_val   = TURN_LD;
                        end
                        !right_object_detected: begin
                            state_d = ST_PIVOT_R;
                            t_load  = 1'b1;
                            t_val   = TURN_LD;
                        end
                        default: begin
                            state_d = ST_REVERSE;
                            t_load  = 1'b1;
                            t_val   = REV_LD;
                            if (retry_cnt != MAX_R) retry_d = retry_cnt + 1'b1;
                        end
                    endcase
                end
                ST_PIVOT_L, ST_PIVOT_R: begin
                    if (t_done) begin
                        state_d = ST_FWD;
                        t_load  = 1'b1;
                        t_val   = CLR_LD;
                    end else begin
                        t_dec = 1'b1;
                    end
                end
                ST_REVERSE: begin
                    if (!t_done) begin
                        t_dec = 1'b1;
                    end else if (retry_cnt == MAX_R) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_PIVOT_R;
                        t_load  = 1'b1;
                        t_val   = TURN_LD;
                    end
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            motor_cmd <= CMD_STOP;
            busy      <= 1'b0;
            stuck     <= 1'b0;
            retry_cnt <= '0;
        end else begin
            state     <= state_d;
            motor_cmd <= cmd_of(state_d);
            busy      <= (state_d == ST_PIVOT_L) ||
                         (state_d == ST_PIVOT_R) ||
                         (state_d == ST_REVERSE);
            stuck     <= (state_d == ST_HALT);
            retry_cnt <= retry_d;
        end
    end

endmodule

// File: tb/tb_obj_nav_ctrl.sv
// Scoreboard bench for obj_nav_ctrl: directed scenarios then random flags
// checked against a phase/elapsed-time reference model.
module tb_obj_nav_ctrl;

    localparam int TURN  = 16;
    localparam int REV   = 8;
    localparam int CLR   = 32;
    localparam int MAXR  = 3;
    localparam int CNT_W = 8;

    localparam int M_IDLE = 0;
    localparam int M_FWD  = 1;
    localparam int M_PL   = 2;
    localparam int M_PR   = 3;
    localparam int M_REV  = 4;
    localparam int M_HALT = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       left_d = 1'b0;
    logic       right_d = 1'b0;
    logic       front_d = 1'b0;
    logic [2:0] motor_cmd;
    logic       busy;
    logic       stuck;
    logic [1:0] retry_cnt;

    always #5 clk = ~clk;

    obj_nav_ctrl #(
        .TURN_CYCLES  (TURN),
        .REV_CYCLES   (REV),
        .CLEAR_CYCLES (CLR),
        .MAX_RETRY    (MAXR),
        .CNT_W        (CNT_W)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .enable                (enable),
        .left_object_detected  (left_d),
        .right_object_detected (right_d),
        .front_object_detected (front_d),
        .motor_cmd             (motor_cmd),
        .busy                  (busy),
        .stuck                 (stuck),
        .retry_cnt             (retry_cnt)
    );

    typedef struct packed {
        logic [2:0] cmd;
        logic       busy;
        logic       stuck;
        logic [1:0] retry;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    int m_mode = M_IDLE;
    int m_elapsed = 0;
    int m_clear = 0;
    int m_retry = 0;

    task automatic model_step(input bit r, input bit e, input bit f,
                              input bit l, input bit rt);
        exp_t x;
        if (!r || !e) begin
            m_mode  = M_IDLE;
            m_retry = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_mode  = M_FWD;
                    m_clear = 0;
                end
                M_FWD: begin
                    if (f) begin
                        if (!l) m_mode = M_PL;
                        else if (!rt) m_mode = M_PR;
                        else begin
                            m_mode = M_REV;
                            if (m_retry < MAXR) m_retry++;
                        end
                        m_elapsed = 1;
                    end else begin
                        m_clear++;
                        if (m_clear >= CLR) m_retry = 0;
                    end
                end
                M_PL, M_PR: begin
                    if (m_elapsed == TURN) begin
                        m_mode  = M_FWD;
                        m_clear = 0;
                    end else m_elapsed++;
                end
                M_REV: begin
                    if (m_elapsed == REV) begin
                        if (m_retry == MAXR) m_mode = M_HALT;
                        else begin
                            m_mode    = M_PR;
                            m_elapsed = 1;
                        end
                    end else m_elapsed++;
                end
                default: ;
            endcase
        end
        case (m_mode)
            M_FWD:   x.cmd = 3'd1;
            M_PL:    x.cmd = 3'd2;
            M_PR:    x.cmd = 3'd3;
            M_REV:   x.cmd = 3'd4;
            default: x.cmd = 3'd0;
        endcase
        x.busy  = (m_mode == M_PL || m_mode == M_PR || m_mode == M_REV);
        x.stuck = (m_mode == M_HALT);
        x.retry = 2'(m_retry);
        q.push_back(x);
    endtask

    task automatic drive(input bit r, input bit e, input bit f,
                         input bit l, input bit rt);
        @(negedge clk);
        reset   = r;
        enable  = e;
        front_d = f;
        left_d  = l;
        right_d = rt;
        model_step(r, e, f, l, rt);
    endtask

    task automatic idle_run(input int n);
        for (int i = 0; i < n; i++) drive(1, 1, 0, $urandom_range(0, 1),
                                          $urandom_range(0, 1));
    endtask

    initial begin : monitor
        exp_t x;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                x   = q.pop_front();
                got = {motor_cmd, busy, stuck, retry_cnt};
                checks++;
                if (got !== x) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got cmd=%0d busy=%0b stuck=%0b retry=%0d, required cmd=%0d busy=%0b stuck=%0b retry=%0d",
                             cyc, got.cmd, got.busy, got.stuck, got.retry,
                             x.cmd, x.busy, x.stuck, x.retry);
                end
            end
        end
    end

    initial begin : stim
        bit boxed;
        bit e, r, f, l, rt;
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0);
        idle_run(6);
        drive(1, 1, 1, 0, 0);
        idle_run(20);
        drive(1, 1, 1, 1, 0);
        idle_run(20);
        for (int i = 0; i < 80; i++) drive(1, 1, 1, 1, 1);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        idle_run(2);
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 1, 1, 1);
            idle_run(25);
        end
        idle_run(40);
        drive(1, 1, 1, 1, 1);
        idle_run(30);
        drive(1, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 1, 1);
        drive(0, 1, 1, 1, 1);
        idle_run(3);
        drive(1, 1, 1, 0, 1);
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0);
        drive(1, 0, 1, 1, 1);
        idle_run(20);
        boxed = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) boxed = !boxed;
            e  = ($urandom_range(0, 99) != 0);
            r  = ($urandom_range(0, 299) != 0);
            f  = boxed || ($urandom_range(0, 3) == 0);
            l  = boxed || ($urandom_range(0, 1) == 1);
            rt = boxed || ($urandom_range(0, 9) < 7);
            drive(r, e, f, l, rt);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
